vector_proc_core: RTL and testbench

`vector_proc_core` is a small in-order vector processor with a scalar control path. It fetches 32-bit instructions from an external byte-addressed instruction memory and runs strip-mined vector loops against an external 8-lane, row-addressed data memory. It holds 32 scalar and 32 vector architectural registers. It executes one instruction at a time through a fixed multi-cycle FSM and signals `done` on HALT.

---
 rtl/vector_proc_core_if.sv | 33 +++
 rtl/vector_proc_core.sv | 188 ++++++++++++++++++
 tb/tb_vector_proc_core.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_proc_core_if.sv
// Instruction- and data-memory bus between vector_proc_core and its memories.
interface vector_proc_core_if #(
  parameter int unsigned LANES = 8
);
  localparam int unsigned ROW_W = LANES * 32;

  logic [5:0]       imem_addr;
  logic [31:0]      imem_rdata;
  logic [6:0]       dmem_addr;
  logic [ROW_W-1:0] dmem_rdata;
  logic [ROW_W-1:0] dmem_wdata;
  logic             dmem_we;

  // Core side
  modport master (
    output imem_addr,
    input  imem_rdata,
    output dmem_addr,
    input  dmem_rdata,
    output dmem_wdata,
    output dmem_we
  );

  // Memory side
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  dmem_addr,
    output dmem_rdata,
    input  dmem_wdata,
    input  dmem_we
  );
endinterface

// File: rtl/vector_proc_core.sv
// In-order vector processor: one instruction at a time through FETCH/DECODE/EXEC,
// vector loads/stores move one 8-lane row per EXEC beat.
module vector_proc_core #(
  parameter int unsigned LANES = 8,
  parameter int unsigned VLEN  = 32,
  parameter int unsigned BEATS = VLEN / LANES
) (
  input  logic               clk,
  input  logic               rst,
  vector_proc_core_if.master bus,
  output logic [5:0]         pc_o,
  output logic               done
);
  localparam int unsigned ROW_W  = LANES * 32;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [LANES-1:0][31:0] row_t;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [5:0] OP_LV   = 6'h01;
  localparam logic [5:0] OP_SV   = 6'h02;
  localparam logic [5:0] OP_ADDV = 6'h03;
  localparam logic [5:0] OP_SUBV = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_SUB  = 6'h06;
  localparam logic [5:0] OP_BNE  = 6'h07;
  localparam logic [5:0] OP_HALT = 6'h3F;

  logic [1:0]        state;
  logic [1:0]        state_d;
  logic [5:0]        pc;
  logic [31:0]       ir;
  logic [BEAT_W-1:0] beat;
  logic [6:0]        base;
  logic [31:0]       a_val;
  logic [31:0]       b_val;
  logic [31:0]       c_val;
  logic [31:0]       sreg [NREGS];
  row_t              vreg [NREGS][BEATS];

  logic [5:0]       op_c;
  logic [REG_W-1:0] fa_c;
  logic [REG_W-1:0] fb_c;
  logic [REG_W-1:0] fc_c;
  logic [31:0]      imm_c;
  logic [31:0]      rd_a_c;
  logic [31:0]      rd_b_c;
  logic [31:0]      rd_c_c;
  logic             is_vec_c;
  logic             last_beat_c;
  logic [5:0]       next_pc_c;

  assign op_c  = ir[31:26];
  assign fa_c  = ir[25:21];
  assign fb_c  = ir[20:16];
  assign fc_c  = ir[15:11];
  assign imm_c = {{16{ir[15]}}, ir[15:0]};

  // R0 always reads as zero regardless of what the array holds
  assign rd_a_c = (fa_c == '0) ? 32'd0 : sreg[fa_c];
  assign rd_b_c = (fb_c == '0) ? 32'd0 : sreg[fb_c];
  assign rd_c_c = (fc_c == '0) ? 32'd0 : sreg[fc_c];

  assign is_vec_c    = (op_c == OP_LV) || (op_c == OP_SV) ||
                       (op_c == OP_ADDV) || (op_c == OP_SUBV);
  assign last_beat_c = (beat == BEAT_W'(BEATS - 1));
  assign next_pc_c   = ((op_c == OP_BNE) && (a_val != b_val)) ?
                       (pc + 6'd4 + imm_c[5:0]) : (pc + 6'd4);

  assign bus.imem_addr = pc;
  assign pc_o          = pc;

  // Lanewise 32-bit wraparound add or subtract of two rows
  function automatic row_t lane_op(input row_t x, input row_t y, input logic sub);
    row_t r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[LANE_W'(i)] = sub ? (x[LANE_W'(i)] - y[LANE_W'(i)])
                          : (x[LANE_W'(i)] + y[LANE_W'(i)]);
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_d;
  end

  // Next-state logic: vector ops stay in EXEC until the last beat
  always_comb begin
    state_d = state;
    unique case (state)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (op_c == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   if (!is_vec_c || last_beat_c) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath, register files and registered memory-bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= '0;
      ir             <= '0;
      beat           <= '0;
      base           <= '0;
      a_val          <= '0;
      b_val          <= '0;
      c_val          <= '0;
      done           <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_we    <= 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        sreg[REG_W'(r)] <= '0;
        for (int k = 0; k < BEATS; k++) begin
          vreg[REG_W'(r)][BEAT_W'(k)] <= '0;
        end
      end
      sreg[REG_W'(2)] <= 32'd40;
      sreg[REG_W'(3)] <= 32'd80;
      sreg[REG_W'(4)] <= 32'd1;
      sreg[REG_W'(5)] <= 32'd10;
    end else begin
      case (state)
        S_FETCH: ir <= bus.imem_rdata;

        S_DECODE: begin
          a_val <= rd_a_c;
          b_val <= rd_b_c;
          c_val <= rd_c_c;
          base  <= rd_b_c[6:0];
          beat  <= '0;
          // Present beat 0 of a load/store so it is on the bus during EXEC beat 0
          if ((op_c == OP_LV) || (op_c == OP_SV)) bus.dmem_addr <= rd_b_c[6:0];
          if (op_c == OP_SV) begin
            bus.dmem_we    <= 1'b1;
            bus.dmem_wdata <= vreg[fa_c][BEAT_W'(0)];
          end
          if (op_c == OP_HALT) done <= 1'b1;
        end

        S_EXEC: begin
          beat <= beat + BEAT_W'(1);
          case (op_c)
            OP_LV: begin
              vreg[fa_c][beat] <= bus.dmem_rdata;
              if (!last_beat_c) bus.dmem_addr <= base + 7'(beat) + 7'd1;
            end
            OP_SV: begin
              if (last_beat_c) begin
                bus.dmem_we <= 1'b0;
              end else begin
                bus.dmem_addr  <= base + 7'(beat) + 7'd1;
                bus.dmem_wdata <= vreg[fa_c][beat + BEAT_W'(1)];
              end
            end
            OP_ADDV, OP_SUBV: begin
              // Whole vector in beat 0 so a source aliasing the destination reads old data
              if (beat == '0) begin
                for (int k = 0; k < BEATS; k++) begin
                  vreg[fa_c][BEAT_W'(k)] <= lane_op(vreg[fb_c][BEAT_W'(k)],
                                                    vreg[fc_c][BEAT_W'(k)],
                                                    op_c == OP_SUBV);
                end
              end
            end
            OP_ADDI: if (fa_c != '0) sreg[fa_c] <= b_val + imm_c;
            OP_SUB:  if (fa_c != '0) sreg[fa_c] <= b_val - c_val;
            default: ;
          endcase
          if (!is_vec_c || last_beat_c) pc <= next_pc_c;
        end

        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_proc_core.sv
// Scoreboard bench for vector_proc_core: expected row writes and pc trace are
// queued when a program is loaded and popped as the core produces them.
module tb_vector_proc_core;
  localparam int unsigned LANES = 8;
  localparam int unsigned ROW_W = LANES * 32;

  typedef logic [LANES-1:0][31:0] row_t;
  typedef struct {
    logic [6:0] addr;
    row_t       data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] pc_o;
  logic       done;

  int vecs = 0;
  int errs = 0;

  wr_t        exp_q [$];
  logic [5:0] pc_q  [$];

  logic [7:0] imem [64];
  row_t       dmem [128];

  vector_proc_core_if #(.LANES(LANES)) bus ();

  vector_proc_core #(.LANES(LANES), .VLEN(32), .BEATS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.master),
    .pc_o (pc_o),
    .done (done)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = {imem[bus.imem_addr], imem[bus.imem_addr + 6'd1],
                           imem[bus.imem_addr + 6'd2], imem[bus.imem_addr + 6'd3]};
  assign bus.dmem_rdata = dmem[bus.dmem_addr];

  always @(posedge clk) begin
    if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] lo);
    return {op, a, b, lo};
  endfunction

  function automatic logic [15:0] rc(input logic [4:0] c);
    return {c, 11'd0};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    imem[6'(addr)]     = w[31:24];
    imem[6'(addr + 1)] = w[23:16];
    imem[6'(addr + 2)] = w[15:8];
    imem[6'(addr + 3)] = w[7:0];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[6'(i)] = 8'h00;
    for (int r = 0; r < 128; r++) dmem[7'(r)] = '0;
    exp_q.delete();
    pc_q.delete();
  endtask

  task automatic start();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
    vecs++; if (pc_o !== 6'd0) begin errs++; $display("FAIL reset_pc got %0d want 0", pc_o); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %0b want 0", done); end
    vecs++; if (bus.dmem_we !== 1'b0) begin errs++; $display("FAIL reset_we got %0b want 0", bus.dmem_we); end
    vecs++; if (bus.dmem_addr !== 7'd0) begin errs++; $display("FAIL reset_addr got %0d want 0", bus.dmem_addr); end
    vecs++; if (bus.dmem_wdata !== '0) begin errs++; $display("FAIL reset_wdata got %h want 0", bus.dmem_wdata); end
  endtask

  task automatic test_canonical();
    wr_t e;
    row_t x;
    int cyc;
    bit seen_done;
    clear_mem();
    put(0,  enc(6'h01, 5'd1, 5'd1, 16'd0));
    put(4,  enc(6'h01, 5'd2, 5'd2, 16'd0));
    put(8,  enc(6'h03, 5'd3, 5'd1, rc(5'd2)));
    put(12, enc(6'h02, 5'd3, 5'd3, 16'd0));
    put(16, enc(6'h05, 5'd1, 5'd1, 16'd4));
    put(20, enc(6'h05, 5'd2, 5'd2, 16'd4));
    put(24, enc(6'h05, 5'd3, 5'd3, 16'd4));
    put(28, enc(6'h06, 5'd5, 5'd5, rc(5'd4)));
    put(32, enc(6'h07, 5'd5, 5'd0, 16'hFFDC));
    put(36, enc(6'h3F, 5'd0, 5'd0, 16'd0));
    for (int r = 0; r < 80; r++) begin
      for (int i = 0; i < LANES; i++) x[3'(i)] = $urandom();
      dmem[7'(r)] = x;
    end
    for (int r = 80; r < 120; r++) begin
      e.addr = 7'(r);
      for (int i = 0; i < LANES; i++)
        e.data[3'(i)] = dmem[7'(r - 80)][3'(i)] + dmem[7'(r - 40)][3'(i)];
      exp_q.push_back(e);
    end
    start();
    seen_done = 1'b0;
    for (cyc = 1; cyc <= 600; cyc++) begin
      @(posedge clk); #1;
      if (bus.dmem_we) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL canon_extra_write row %0d", bus.dmem_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.dmem_addr !== e.addr || bus.dmem_wdata !== e.data) begin
            errs++;
            $display("FAIL canon_row got row %0d %h want row %0d %h", bus.dmem_addr, bus.dmem_wdata, e.addr, e.data);
          end
        end
      end
      if (done) begin seen_done = 1'b1; break; end
    end
    vecs++; if (!seen_done || cyc != 392) begin errs++; $display("FAIL canon_done_cycle got %0d (seen %0b) want 392", cyc, seen_done); end
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL canon_missing_writes got %0d left want 0", exp_q.size()); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vecs++;
      if (pc_o !== 6'd36 || bus.dmem_we !== 1'b0 || done !== 1'b1) begin
        errs++; $display("FAIL canon_halt_hold got pc %0d we %0b done %0b want pc 36 we 0 done 1", pc_o, bus.dmem_we, done);
      end
    end
  endtask

  task automatic test_wrap();
    wr_t e;
    row_t a;
    row_t b;
    int cyc;
    bit seen_done;
    clear_mem();
    put(0,  enc(6'h01, 5'd1, 5'd0, 16'd0));
    put(4,  enc(6'h01, 5'd2, 5'd2, 16'd0));
    put(8,  enc(6'h03, 5'd3, 5'd1, rc(5'd2)));
    put(12, enc(6'h04, 5'd4, 5'd5, rc(5'd2)));
    put(16, enc(6'h03, 5'd1, 5'd1, rc(5'd2)));
    put(20, enc(6'h05, 5'd6, 5'd0, 16'd20));
    put(24, enc(6'h02, 5'd3, 5'd3, 16'd0));
    put(28, enc(6'h02, 5'd4, 5'd5, 16'd0));
    put(32, enc(6'h02, 5'd1, 5'd6, 16'd0));
    put(36, enc(6'h3F, 5'd0, 5'd0, 16'd0));
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LANES; i++) begin
        a[3'(i)] = 32'hFFFF_FFFF - 32'(8 * k + i);
        b[3'(i)] = 32'(8 * k + i + 1);
      end
      dmem[7'(k)]      = a;
      dmem[7'(40 + k)] = b;
    end
    for (int k = 0; k < 4; k++) begin
      e.addr = 7'(80 + k); e.data = '0; exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      e.addr = 7'(10 + k);
      for (int i = 0; i < LANES; i++) e.data[3'(i)] = 32'd0 - 32'(8 * k + i + 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      e.addr = 7'(20 + k); e.data = '0; exp_q.push_back(e);
    end
    start();
    seen_done = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      if (bus.dmem_we) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL wrap_extra_write row %0d", bus.dmem_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.dmem_addr !== e.addr || bus.dmem_wdata !== e.data) begin
            errs++;
            $display("FAIL wrap_row got row %0d %h want row %0d %h", bus.dmem_addr, bus.dmem_wdata, e.addr, e.data);
          end
        end
      end
      if (done) begin seen_done = 1'b1; break; end
    end
    vecs++; if (!seen_done || cyc != 53) begin errs++; $display("FAIL wrap_done_cycle got %0d (seen %0b) want 53", cyc, seen_done); end
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL wrap_missing_writes got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_bne_r0();
    wr_t e;
    row_t x;
    logic [5:0] want_pc;
    logic [5:0] last_pc;
    int cyc;
    bit seen_done;
    clear_mem();
    put(0,  enc(6'h05, 5'd0, 5'd0, 16'd5));
    put(4,  enc(6'h07, 5'd0, 5'd0, 16'd8));
    put(8,  enc(6'h05, 5'd5, 5'd0, 16'd0));
    put(12, enc(6'h07, 5'd5, 5'd0, 16'hFFF4));
    put(16, enc(6'h05, 5'd8, 5'd8, 16'd1));
    put(20, enc(6'h05, 5'd9, 5'd8, 16'hFFFE));
    put(24, enc(6'h07, 5'd9, 5'd0, 16'hFFF4));
    put(28, enc(6'h02, 5'd0, 5'd0, 16'd0));
    put(32, enc(6'h3F, 5'd0, 5'd0, 16'd0));
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < LANES; i++) x[3'(i)] = 32'hC0DE_0000 + 32'(r * 8 + i);
      dmem[7'(r)] = x;
    end
    for (int k = 0; k < 4; k++) begin
      e.addr = 7'(k); e.data = '0; exp_q.push_back(e);
    end
    pc_q = '{6'd0, 6'd4, 6'd8, 6'd12, 6'd16, 6'd20, 6'd24, 6'd16, 6'd20, 6'd24, 6'd28, 6'd32};
    start();
    want_pc = pc_q.pop_front();
    vecs++; if (pc_o !== want_pc) begin errs++; $display("FAIL bne_pc_start got %0d want %0d", pc_o, want_pc); end
    last_pc = pc_o;
    seen_done = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      if (pc_o !== last_pc) begin
        vecs++;
        if (pc_q.size() == 0) begin
          errs++; $display("FAIL bne_pc_extra got %0d", pc_o);
        end else begin
          want_pc = pc_q.pop_front();
          if (pc_o !== want_pc) begin errs++; $display("FAIL bne_pc_trace got %0d want %0d", pc_o, want_pc); end
        end
        last_pc = pc_o;
      end
      if (bus.dmem_we) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL bne_extra_write row %0d", bus.dmem_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.dmem_addr !== e.addr || bus.dmem_wdata !== e.data) begin
            errs++;
            $display("FAIL bne_r0_row got row %0d %h want row %0d %h", bus.dmem_addr, bus.dmem_wdata, e.addr, e.data);
          end
        end
      end
      if (done) begin seen_done = 1'b1; break; end
    end
    vecs++; if (!seen_done || cyc != 38) begin errs++; $display("FAIL bne_done_cycle got %0d (seen %0b) want 38", cyc, seen_done); end
    vecs++; if (pc_q.size() != 0 || exp_q.size() != 0) begin errs++; $display("FAIL bne_leftover got pcs %0d writes %0d want 0 0", pc_q.size(), exp_q.size()); end
    @(posedge clk); #1;
    vecs++; if (pc_o !== 6'd32) begin errs++; $display("FAIL bne_halt_pc got %0d want 32", pc_o); end
  endtask

  task automatic test_sv_reset();
    wr_t e;
    row_t x;
    row_t src [4];
    row_t sentinel;
    int cyc;
    int nwe;
    bit seen_done;
    clear_mem();
    put(0, enc(6'h01, 5'd1, 5'd1, 16'd0));
    put(4, enc(6'h02, 5'd1, 5'd3, 16'd0));
    put(8, enc(6'h3F, 5'd0, 5'd0, 16'd0));
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LANES; i++) x[3'(i)] = {8'(k), 8'(i), 16'($urandom_range(0, 65535))};
      src[k] = x;
      dmem[7'(k)] = x;
    end
    for (int i = 0; i < LANES; i++) sentinel[3'(i)] = 32'hA5A5_A5A5;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 1) for (int k = 0; k < 4; k++) dmem[7'(80 + k)] = sentinel;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
        e.addr = 7'(80 + k); e.data = src[k]; exp_q.push_back(e);
      end
      start();
      nwe = 0;
      seen_done = 1'b0;
      for (cyc = 1; cyc <= 100; cyc++) begin
        @(posedge clk); #1;
        if (bus.dmem_we) begin
          nwe++;
          vecs++;
          if (exp_q.size() == 0) begin
            errs++; $display("FAIL sv_extra_write row %0d", bus.dmem_addr);
          end else begin
            e = exp_q.pop_front();
            if (bus.dmem_addr !== e.addr || bus.dmem_wdata !== e.data) begin
              errs++;
              $display("FAIL sv_row got row %0d %h want row %0d %h", bus.dmem_addr, bus.dmem_wdata, e.addr, e.data);
            end
          end
          if (pass == 1 && nwe == 3) break;
        end
        if (done) begin seen_done = 1'b1; break; end
      end
      if (pass == 1) begin
        // Abort during store beat 2, between clock edges
        #1 rst = 1'b1;
        #1;
        vecs++; if (bus.dmem_we !== 1'b0) begin errs++; $display("FAIL abort_we got %0b want 0", bus.dmem_we); end
        vecs++; if (pc_o !== 6'd0) begin errs++; $display("FAIL abort_pc got %0d want 0", pc_o); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL abort_done got %0b want 0", done); end
        @(negedge clk);
        vecs++; if (dmem[7'd80] !== src[0] || dmem[7'd81] !== src[1]) begin errs++; $display("FAIL abort_kept_rows got %h %h", dmem[7'd80], dmem[7'd81]); end
        vecs++; if (dmem[7'd82] !== sentinel || dmem[7'd83] !== sentinel) begin errs++; $display("FAIL abort_unwritten_rows got %h %h", dmem[7'd82], dmem[7'd83]); end
      end else begin
        vecs++; if (!seen_done || cyc != 14) begin errs++; $display("FAIL sv_done_cycle got %0d (seen %0b) want 14", cyc, seen_done); end
        vecs++; if (nwe != 4) begin errs++; $display("FAIL sv_we_cycles got %0d want 4", nwe); end
      end
    end
    vecs++;
    if (dmem[7'd82] !== src[2] || dmem[7'd83] !== src[3]) begin
      errs++; $display("FAIL rerun_rows got %h %h want %h %h", dmem[7'd82], dmem[7'd83], src[2], src[3]);
    end
  endtask

  initial begin
    test_reset();
    test_canonical();
    test_wrap();
    test_bne_r0();
    test_sv_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
